// File: rtl/frame_watchdog_ctrl.sv
// Frame watchdog: header-checked atomic latch of joint commands, arming after N good frames, safe state on host timeout.
// Latency: outputs are registered, 1 cycle from strobe; no backpressure, every strobe is consumed in its own cycle.
module frame_watchdog_ctrl #(
  parameter int          NUM_JOINTS     = 5,
  parameter int          TIMEOUT_CYCLES = 4800000,
  parameter int          REARM_FRAMES   = 3,
  parameter logic [31:0] HEADER         = 32'h74697277,
  parameter logic [7:0]  DOUT_SAFE      = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_strobe,
  input  logic [31:0]              frame_header,
  input  logic [32*NUM_JOINTS-1:0] freq_cmd_in,
  input  logic [NUM_JOINTS-1:0]    enable_in,
  input  logic [7:0]               dout_in,
  output logic [32*NUM_JOINTS-1:0] freq_cmd_out,
  output logic [NUM_JOINTS-1:0]    enable_out,
  output logic [7:0]               dout_out,
  output logic [1:0]               state,
  output logic [7:0]               fault_count,
  output logic [7:0]               bad_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (REARM_FRAMES < 2) ? 1 : $clog2(REARM_FRAMES + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] REARM  = CW'(REARM_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    RUN    = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t                     cur_state, nxt_state;
  logic [CW-1:0]              good_cnt, good_cnt_nxt, good_cnt_inc;
  logic [TW-1:0]              timer, timer_nxt;
  logic [32*NUM_JOINTS-1:0]   freq_sh, freq_sh_nxt, freq_nxt;
  logic [NUM_JOINTS-1:0]      enable_sh, enable_sh_nxt, enable_nxt;
  logic [7:0]                 dout_sh, dout_sh_nxt, dout_nxt;
  logic                       good, bad, timeout, fault_inc;

  assign good         = frame_strobe && (frame_header == HEADER);
  assign bad          = frame_strobe && !good;
  assign timeout      = (timer == T_LAST) && !good;
  assign good_cnt_inc = good_cnt + CW'(1);
  assign state        = cur_state;

  assign timer_nxt     = good ? '0 : ((timer == T_MAX) ? timer : timer + TW'(1));
  assign freq_sh_nxt   = good ? freq_cmd_in : freq_sh;
  assign enable_sh_nxt = good ? enable_in   : enable_sh;
  assign dout_sh_nxt   = good ? dout_in     : dout_sh;

  always_comb begin
    nxt_state    = cur_state;
    good_cnt_nxt = good_cnt;
    fault_inc    = 1'b0;
    case (cur_state)
      IDLE, FAULT: begin
        // A lone arming frame suffices when REARM_FRAMES is 1, else ARMING would never complete.
        if (good) begin
          good_cnt_nxt = CW'(1);
          nxt_state    = (REARM_FRAMES == 1) ? RUN : ARMING;
        end
      end
      ARMING: begin
        if (good) begin
          good_cnt_nxt = good_cnt_inc;
          if (good_cnt_inc >= REARM) nxt_state = RUN;
        end else if (bad || timeout) begin
          good_cnt_nxt = '0;
          nxt_state    = IDLE;
        end
      end
      RUN: begin
        if (timeout) begin
          nxt_state = FAULT;
          fault_inc = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Output registers are loaded from next state and next shadow so a frame is visible one cycle after its strobe.
  always_comb begin
    freq_nxt   = '0;
    enable_nxt = '0;
    dout_nxt   = DOUT_SAFE;
    if (nxt_state == RUN) begin
      enable_nxt = enable_sh_nxt;
      dout_nxt   = dout_sh_nxt;
      for (int j = 0; j < NUM_JOINTS; j++) begin
        if (enable_sh_nxt[j]) freq_nxt[32*j +: 32] = freq_sh_nxt[32*j +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state    <= IDLE;
      good_cnt     <= '0;
      timer        <= '0;
      freq_sh      <= '0;
      enable_sh    <= '0;
      dout_sh      <= '0;
      freq_cmd_out <= '0;
      enable_out   <= '0;
      dout_out     <= DOUT_SAFE;
      fault_count  <= '0;
      bad_count    <= '0;
    end else begin
      cur_state    <= nxt_state;
      good_cnt     <= good_cnt_nxt;
      timer        <= timer_nxt;
      freq_sh      <= freq_sh_nxt;
      enable_sh    <= enable_sh_nxt;
      dout_sh      <= dout_sh_nxt;
      freq_cmd_out <= freq_nxt;
      enable_out   <= enable_nxt;
      dout_out     <= dout_nxt;
      if (fault_inc && (fault_count != 8'hFF)) fault_count <= fault_count + 8'd1;
      if (bad && (bad_count != 8'hFF))         bad_count   <= bad_count + 8'd1;
    end
  end

endmodule
